tinyml_nn_cycle_counter_arbiter: RTL and testbench

Shares the fabric cycle counter between up to N_REQ profiling requesters in the tinyml_nn SoC, such as the HLS accelerator wrapper, DMA monitors and the MSS-side sequencer. Each requester either samples the counter (AXI4 read) or clears it (AXI4 write of zero). The block arbitrates round-robin, issues one single-beat AXI4 transaction at a time as initiator, and returns the 48-bit timestamp or completion to the winning requester.

---
 rtl/tinyml_nn_cycle_counter_arbiter.sv | 264 ++++++++++++++++++++++++++
 tb/tb_tinyml_nn_cycle_counter_arbiter.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tinyml_nn_cycle_counter_arbiter.sv
// tinyml_nn_cycle_counter_arbiter
// Round-robin arbiter that lets up to N_REQ profiling requesters sample
// (AXI4 read) or clear (AXI4 write of zero) the shared fabric cycle counter.
// One single-beat AXI4 transaction is in flight at a time.
// Optional watchdog: define TINYML_NN_CCARB_TIMEOUT_EN to abort a stuck
// transaction after TIMEOUT_CYCLES cycles in any handshake-wait state.
module tinyml_nn_cycle_counter_arbiter #(
    parameter int N_REQ          = 4,
    parameter int AXI_DATA_WIDTH = 64,
    parameter int AXI_ID_WIDTH   = 5,
    parameter int AXI_ADDR_WIDTH = 8,
    parameter int COUNTER_ADDR   = 0,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                        i_clk,
    input  logic                        i_reset,
    input  logic [N_REQ-1:0]            i_req_valid,
    input  logic [N_REQ-1:0]            i_req_clear,
    output logic [N_REQ-1:0]            o_req_done,
    output logic [47:0]                 o_rsp_data,
    output logic                        o_rsp_err,
    // AR
    output logic                        o_arvalid,
    input  logic                        i_arready,
    output logic [AXI_ADDR_WIDTH-1:0]   o_araddr,
    output logic [AXI_ID_WIDTH-1:0]     o_arid,
    output logic [7:0]                  o_arlen,
    output logic [2:0]                  o_arsize,
    output logic [1:0]                  o_arburst,
    // R
    input  logic                        i_rvalid,
    output logic                        o_rready,
    input  logic [AXI_DATA_WIDTH-1:0]   i_rdata,
    input  logic [AXI_ID_WIDTH-1:0]     i_rid,
    input  logic [1:0]                  i_rresp,
    input  logic                        i_rlast,
    // AW
    output logic                        o_awvalid,
    input  logic                        i_awready,
    output logic [AXI_ADDR_WIDTH-1:0]   o_awaddr,
    output logic [AXI_ID_WIDTH-1:0]     o_awid,
    output logic [7:0]                  o_awlen,
    output logic [2:0]                  o_awsize,
    output logic [1:0]                  o_awburst,
    // W
    output logic                        o_wvalid,
    input  logic                        i_wready,
    output logic [AXI_DATA_WIDTH-1:0]   o_wdata,
    output logic [AXI_DATA_WIDTH/8-1:0] o_wstrb,
    output logic                        o_wlast,
    // B
    input  logic                        i_bvalid,
    output logic                        o_bready,
    input  logic [AXI_ID_WIDTH-1:0]     i_bid,
    input  logic [1:0]                  i_bresp
);

    localparam int GW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    typedef enum logic [2:0] {
        S_IDLE, S_RD_ADDR, S_RD_DATA, S_WR_REQ, S_WR_RESP, S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [GW-1:0]      rr_ptr_q, rr_ptr_d;
    logic [GW-1:0]      grant_q, grant_d;
    logic               arvalid_q, arvalid_d;
    logic               rready_q, rready_d;
    logic               awvalid_q, awvalid_d;
    logic               wvalid_q, wvalid_d;
    logic               bready_q, bready_d;
    logic [N_REQ-1:0]   done_q, done_d;
    logic [47:0]        rsp_data_q, rsp_data_d;
    logic               rsp_err_q, rsp_err_d;

    logic               gnt_found;
    logic [GW-1:0]      gnt_idx;
    logic [GW-1:0]      gnt_next;
    logic [AXI_ID_WIDTH-1:0] grant_id;

`ifdef TINYML_NN_CCARB_TIMEOUT_EN
    logic [15:0]        wd_q, wd_d;
    logic               waiting;
    logic               wd_expired;
`endif

    // Upper read-data bits and rlast carry nothing for a single 48-bit beat.
    logic unused_ok;
    assign unused_ok = ^{i_rlast, i_rdata[AXI_DATA_WIDTH-1:48], TIMEOUT_CYCLES[0]};

    assign grant_id = AXI_ID_WIDTH'(grant_q);

    // Round-robin search: first active requester at or after rr_ptr, wrapping.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (!gnt_found && i_req_valid[(int'(rr_ptr_q) + i) % N_REQ]) begin
                gnt_found = 1'b1;
                gnt_idx   = GW'((int'(rr_ptr_q) + i) % N_REQ);
            end
        end
        gnt_next = (int'(gnt_idx) == N_REQ - 1) ? '0 : gnt_idx + 1'b1;
    end

    // Transaction FSM next-state and registered-output logic.
    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        grant_d    = grant_q;
        arvalid_d  = arvalid_q;
        rready_d   = rready_q;
        awvalid_d  = awvalid_q;
        wvalid_d   = wvalid_q;
        bready_d   = bready_q;
        done_d     = '0;
        rsp_data_d = rsp_data_q;
        rsp_err_d  = rsp_err_q;

        case (state_q)
            S_IDLE: begin
                if (gnt_found) begin
                    grant_d  = gnt_idx;
                    rr_ptr_d = gnt_next;
                    if (i_req_clear[gnt_idx]) begin
                        state_d   = S_WR_REQ;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                    end else begin
                        state_d   = S_RD_ADDR;
                        arvalid_d = 1'b1;
                    end
                end
            end
            S_RD_ADDR: begin
                if (i_arready) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = S_RD_DATA;
                end
            end
            S_RD_DATA: begin
                if (i_rvalid) begin
                    rready_d         = 1'b0;
                    rsp_data_d       = i_rdata[47:0];
                    rsp_err_d        = (i_rresp != 2'b00) || (i_rid != grant_id);
                    done_d[grant_q]  = 1'b1;
                    state_d          = S_DONE;
                end
            end
            S_WR_REQ: begin
                // AW and W are accepted independently; move on once both are gone.
                if (i_awready) awvalid_d = 1'b0;
                if (i_wready)  wvalid_d  = 1'b0;
                if (!awvalid_d && !wvalid_d) begin
                    bready_d = 1'b1;
                    state_d  = S_WR_RESP;
                end
            end
            S_WR_RESP: begin
                if (i_bvalid) begin
                    bready_d         = 1'b0;
                    rsp_data_d       = '0;
                    rsp_err_d        = (i_bresp != 2'b00) || (i_bid != grant_id);
                    done_d[grant_q]  = 1'b1;
                    state_d          = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

`ifdef TINYML_NN_CCARB_TIMEOUT_EN
        // Watchdog abort wins over any handshake seen in the same cycle.
        if (wd_expired) begin
            arvalid_d        = 1'b0;
            rready_d         = 1'b0;
            awvalid_d        = 1'b0;
            wvalid_d         = 1'b0;
            bready_d         = 1'b0;
            rsp_data_d       = '0;
            rsp_err_d        = 1'b1;
            done_d           = '0;
            done_d[grant_q]  = 1'b1;
            state_d          = S_DONE;
        end
`endif
    end

`ifdef TINYML_NN_CCARB_TIMEOUT_EN
    // Watchdog counts cycles spent in a wait state and restarts on each entry.
    always_comb begin
        waiting    = (state_q == S_RD_ADDR) || (state_q == S_RD_DATA) ||
                     (state_q == S_WR_REQ)  || (state_q == S_WR_RESP);
        wd_expired = waiting && (wd_q == 16'(TIMEOUT_CYCLES));
        wd_d       = (waiting && !wd_expired && (state_d == state_q)) ? wd_q + 16'd1 : 16'd0;
    end

    // Watchdog register.
    always_ff @(posedge i_clk) begin
        if (i_reset) wd_q <= '0;
        else         wd_q <= wd_d;
    end
`endif

    // State and output registers; reset abandons any in-flight transaction.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q    <= S_IDLE;
            rr_ptr_q   <= '0;
            grant_q    <= '0;
            arvalid_q  <= 1'b0;
            rready_q   <= 1'b0;
            awvalid_q  <= 1'b0;
            wvalid_q   <= 1'b0;
            bready_q   <= 1'b0;
            done_q     <= '0;
            rsp_data_q <= '0;
            rsp_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            grant_q    <= grant_d;
            arvalid_q  <= arvalid_d;
            rready_q   <= rready_d;
            awvalid_q  <= awvalid_d;
            wvalid_q   <= wvalid_d;
            bready_q   <= bready_d;
            done_q     <= done_d;
            rsp_data_q <= rsp_data_d;
            rsp_err_q  <= rsp_err_d;
        end
    end

    assign o_req_done = done_q;
    assign o_rsp_data = rsp_data_q;
    assign o_rsp_err  = rsp_err_q;

    assign o_arvalid  = arvalid_q;
    assign o_araddr   = AXI_ADDR_WIDTH'(COUNTER_ADDR);
    assign o_arid     = grant_id;
    assign o_arlen    = 8'd0;
    assign o_arsize   = 3'd3;
    assign o_arburst  = 2'b01;
    assign o_rready   = rready_q;

    assign o_awvalid  = awvalid_q;
    assign o_awaddr   = AXI_ADDR_WIDTH'(COUNTER_ADDR);
    assign o_awid     = grant_id;
    assign o_awlen    = 8'd0;
    assign o_awsize   = 3'd3;
    assign o_awburst  = 2'b01;

    assign o_wvalid   = wvalid_q;
    assign o_wdata    = '0;
    assign o_wstrb    = '1;
    assign o_wlast    = 1'b1;
    assign o_bready   = bready_q;

endmodule

// File: tb/tb_tinyml_nn_cycle_counter_arbiter.sv
// Directed bench for tinyml_nn_cycle_counter_arbiter with a small AXI4
// counter target model (configurable ready delays, response faults).
module tb_tinyml_nn_cycle_counter_arbiter;

    localparam int NR = 4;
`ifdef TINYML_NN_CCARB_TIMEOUT_EN
    localparam int TO = 16;
`else
    localparam int TO = 255;
`endif

    logic            i_clk = 1'b0;
    logic            i_reset = 1'b1;
    logic [NR-1:0]   i_req_valid = '0;
    logic [NR-1:0]   i_req_clear = '0;
    logic [NR-1:0]   o_req_done;
    logic [47:0]     o_rsp_data;
    logic            o_rsp_err;
    logic            o_arvalid, i_arready;
    logic [7:0]      o_araddr;
    logic [4:0]      o_arid;
    logic [7:0]      o_arlen;
    logic [2:0]      o_arsize;
    logic [1:0]      o_arburst;
    logic            i_rvalid = 1'b0, o_rready;
    logic [63:0]     i_rdata = '0;
    logic [4:0]      i_rid = '0;
    logic [1:0]      i_rresp = '0;
    logic            i_rlast;
    logic            o_awvalid, i_awready;
    logic [7:0]      o_awaddr;
    logic [4:0]      o_awid;
    logic [7:0]      o_awlen;
    logic [2:0]      o_awsize;
    logic [1:0]      o_awburst;
    logic            o_wvalid, i_wready;
    logic [63:0]     o_wdata;
    logic [7:0]      o_wstrb;
    logic            o_wlast;
    logic            i_bvalid = 1'b0, o_bready;
    logic [4:0]      i_bid = '0;
    logic [1:0]      i_bresp = '0;

    tinyml_nn_cycle_counter_arbiter #(
        .N_REQ(NR), .AXI_DATA_WIDTH(64), .AXI_ID_WIDTH(5), .AXI_ADDR_WIDTH(8),
        .COUNTER_ADDR(0), .TIMEOUT_CYCLES(TO)
    ) dut (
        .i_clk(i_clk), .i_reset(i_reset),
        .i_req_valid(i_req_valid), .i_req_clear(i_req_clear),
        .o_req_done(o_req_done), .o_rsp_data(o_rsp_data), .o_rsp_err(o_rsp_err),
        .o_arvalid(o_arvalid), .i_arready(i_arready), .o_araddr(o_araddr), .o_arid(o_arid),
        .o_arlen(o_arlen), .o_arsize(o_arsize), .o_arburst(o_arburst),
        .i_rvalid(i_rvalid), .o_rready(o_rready), .i_rdata(i_rdata), .i_rid(i_rid),
        .i_rresp(i_rresp), .i_rlast(i_rlast),
        .o_awvalid(o_awvalid), .i_awready(i_awready), .o_awaddr(o_awaddr), .o_awid(o_awid),
        .o_awlen(o_awlen), .o_awsize(o_awsize), .o_awburst(o_awburst),
        .o_wvalid(o_wvalid), .i_wready(i_wready), .o_wdata(o_wdata), .o_wstrb(o_wstrb),
        .o_wlast(o_wlast),
        .i_bvalid(i_bvalid), .o_bready(o_bready), .i_bid(i_bid), .i_bresp(i_bresp)
    );

    always #5 i_clk = ~i_clk;

    // ---------------- counter target model ----------------
    logic [47:0] cnt = '0;
    logic        cnt_run = 1'b0;
    logic        preset_en = 1'b0;
    logic [47:0] preset_val = '0;
    int          ar_delay = 0, aw_delay = 0;
    int          ar_wait = 0, aw_wait = 0;
    logic        r_hold = 1'b0;
    logic [1:0]  rresp_cfg = 2'b00;
    logic [4:0]  rid_flip = '0, bid_flip = '0;
    logic        aw_got = 1'b0, w_got = 1'b0;
    logic        aw_nx, w_nx;

    assign i_arready = (ar_wait >= ar_delay);
    assign i_awready = (aw_wait >= aw_delay);
    assign i_wready  = 1'b1;
    assign i_rlast   = 1'b1;
    assign aw_nx = aw_got | (o_awvalid & i_awready);
    assign w_nx  = w_got  | (o_wvalid  & i_wready);

    always @(posedge i_clk) begin
        if (o_wvalid && i_wready)  cnt <= o_wdata[47:0];
        else if (cnt_run)          cnt <= cnt + 48'd1;
        else if (preset_en)        cnt <= preset_val;

        if (i_reset) begin
            i_rvalid <= 1'b0; i_bvalid <= 1'b0;
            ar_wait <= 0; aw_wait <= 0; aw_got <= 1'b0; w_got <= 1'b0;
        end else begin
            ar_wait <= (o_arvalid && !i_arready) ? ar_wait + 1 : 0;
            aw_wait <= (o_awvalid && !i_awready) ? aw_wait + 1 : 0;
            if (i_rvalid && o_rready) i_rvalid <= 1'b0;
            if (o_arvalid && i_arready && !r_hold) begin
                i_rvalid <= 1'b1;
                i_rdata  <= {16'h0, cnt};
                i_rid    <= o_arid ^ rid_flip;
                i_rresp  <= rresp_cfg;
            end
            if (i_bvalid && o_bready) i_bvalid <= 1'b0;
            if (aw_nx && w_nx) begin
                i_bvalid <= 1'b1;
                i_bid    <= o_awid ^ bid_flip;
                i_bresp  <= 2'b00;
                aw_got   <= 1'b0;
                w_got    <= 1'b0;
            end else begin
                aw_got <= aw_nx;
                w_got  <= w_nx;
            end
        end
    end

    // ---------------- checking ----------------
    int n_chk = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge i_clk);
    endtask

    initial begin
        #400000;
        $display("FAIL global_timeout got=hang exp=finish");
        $fatal(1, "bench time limit");
    end

    initial begin
        int n;
        int dcyc[5];
        logic [3:0] dval[5];
        logic [3:0] acc;
        int hit;

        // reset state
        repeat (3) tick();
        chk("rst_valids", {59'd0, o_arvalid, o_awvalid, o_wvalid, o_rready, o_bready}, 64'd0);
        chk("rst_done", {60'd0, o_req_done}, 64'd0);
        chk("rst_data", {16'd0, o_rsp_data}, 64'd0);
        chk("rst_err", {63'd0, o_rsp_err}, 64'd0);
        i_reset = 1'b0;

        // single sample by requester 2
        preset_val = 48'h0000_1234_5678; preset_en = 1'b1; tick(); preset_en = 1'b0;
        i_req_valid = 4'b0100; i_req_clear = 4'b0000;
        tick();
        chk("s1_arvalid", {63'd0, o_arvalid}, 64'd1);
        chk("s1_araddr", {56'd0, o_araddr}, 64'd0);
        chk("s1_arid", {59'd0, o_arid}, 64'd2);
        chk("s1_arconst", {51'd0, o_arlen, o_arsize, o_arburst}, {51'd0, 8'd0, 3'd3, 2'b01});
        tick();
        chk("s1_rready", {62'd0, o_rready, o_arvalid}, 64'b10);
        tick();
        chk("s1_done", {60'd0, o_req_done}, 64'b0100);
        chk("s1_data", {16'd0, o_rsp_data}, 64'h0000_0000_1234_5678);
        chk("s1_err", {63'd0, o_rsp_err}, 64'd0);
        i_req_valid = '0;
        tick();
        chk("s1_done_off", {60'd0, o_req_done}, 64'd0);
        chk("s1_data_hold", {16'd0, o_rsp_data}, 64'h0000_0000_1234_5678);

        // fairness: all four continuously active after a reset
        i_reset = 1'b1; tick(); i_reset = 1'b0;
        cnt_run = 1'b1;
        n = 0;
        for (int k = 0; k < 5; k++) begin dcyc[k] = 0; dval[k] = '0; end
        i_req_valid = 4'b1111;
        for (int c = 1; c <= 40; c++) begin
            tick();
            if (o_req_done != '0) begin
                dval[n] = o_req_done; dcyc[n] = c; n++;
                if (n == 5) begin i_req_valid = '0; break; end
            end
        end
        cnt_run = 1'b0;
        chk("rr_count", 64'(n), 64'd5);
        chk("rr_g0", {60'd0, dval[0]}, 64'b0001);
        chk("rr_g1", {60'd0, dval[1]}, 64'b0010);
        chk("rr_g2", {60'd0, dval[2]}, 64'b0100);
        chk("rr_g3", {60'd0, dval[3]}, 64'b1000);
        chk("rr_g4", {60'd0, dval[4]}, 64'b0001);
        chk("rr_first_cyc", 64'(dcyc[0]), 64'd3);
        for (int k = 1; k < 5; k++) chk("rr_spacing", 64'(dcyc[k] - dcyc[k-1]), 64'd4);
        tick();

        // clear by requester 1 with awready delayed 3 cycles
        preset_val = 48'h999; preset_en = 1'b1; tick(); preset_en = 1'b0;
        aw_delay = 3;
        i_req_clear = 4'b0010; i_req_valid = 4'b0010;
        tick();
        chk("c_c1", {61'd0, o_awvalid, o_wvalid, o_bready}, 64'b110);
        chk("c_awid", {59'd0, o_awid}, 64'd1);
        chk("c_wconst", {55'd0, o_wstrb, o_wlast}, {55'd0, 8'hff, 1'b1});
        tick(); chk("c_c2", {61'd0, o_awvalid, o_wvalid, o_bready}, 64'b100);
        tick(); chk("c_c3", {61'd0, o_awvalid, o_wvalid, o_bready}, 64'b100);
        tick(); chk("c_c4", {61'd0, o_awvalid, o_wvalid, o_bready}, 64'b100);
        tick(); chk("c_c5", {61'd0, o_awvalid, o_wvalid, o_bready}, 64'b001);
        tick();
        chk("c_done", {60'd0, o_req_done}, 64'b0010);
        chk("c_data", {16'd0, o_rsp_data}, 64'd0);
        chk("c_err", {63'd0, o_rsp_err}, 64'd0);
        i_req_valid = '0; i_req_clear = '0; aw_delay = 0;
        tick();
        i_req_valid = 4'b0010;
        tick(); tick(); tick();
        chk("c_rb_done", {60'd0, o_req_done}, 64'b0010);
        chk("c_rb_range", {63'd0, (o_rsp_data <= 48'd2)}, 64'd1);
        i_req_valid = '0;
        tick();

        // read error response
        rresp_cfg = 2'b10; i_req_valid = 4'b0001;
        tick(); tick(); tick();
        chk("rresp_done", {60'd0, o_req_done}, 64'b0001);
        chk("rresp_err", {63'd0, o_rsp_err}, 64'd1);
        i_req_valid = '0; rresp_cfg = 2'b00;
        tick();

        // read id mismatch
        rid_flip = 5'd1; i_req_valid = 4'b0100;
        tick(); tick(); tick();
        chk("rid_done", {60'd0, o_req_done}, 64'b0100);
        chk("rid_err", {63'd0, o_rsp_err}, 64'd1);
        i_req_valid = '0; rid_flip = '0;
        tick();

        // write id mismatch on a clear
        bid_flip = 5'd4; i_req_clear = 4'b1000; i_req_valid = 4'b1000;
        tick(); tick(); tick();
        chk("bid_done", {60'd0, o_req_done}, 64'b1000);
        chk("bid_err", {63'd0, o_rsp_err}, 64'd1);
        chk("bid_data", {16'd0, o_rsp_data}, 64'd0);
        i_req_valid = '0; i_req_clear = '0; bid_flip = '0;
        tick();

        // clean sample clears the sticky error
        i_req_valid = 4'b0001;
        tick(); tick(); tick();
        chk("ok_err", {63'd0, o_rsp_err}, 64'd0);
        i_req_valid = '0;
        tick();

        // reset while waiting in RD_DATA
        r_hold = 1'b1; i_req_valid = 4'b0100;
        tick(); tick();
        chk("rst_mid_rready", {63'd0, o_rready}, 64'd1);
        i_reset = 1'b1; i_req_valid = '0;
        tick();
        chk("rst_mid_valids", {59'd0, o_arvalid, o_awvalid, o_wvalid, o_rready, o_bready}, 64'd0);
        i_reset = 1'b0; r_hold = 1'b0;
        acc = o_req_done;
        for (int c = 0; c < 3; c++) begin tick(); acc = acc | o_req_done; end
        chk("rst_mid_nodone", {60'd0, acc}, 64'd0);
        i_req_valid = 4'b1001;
        tick();
        chk("rst_mid_arid", {59'd0, o_arid}, 64'd0);
        chk("rst_mid_arvalid", {63'd0, o_arvalid}, 64'd1);
        tick(); tick();
        chk("rst_mid_done", {60'd0, o_req_done}, 64'b0001);
        i_req_valid = '0;
        tick();

`ifdef TINYML_NN_CCARB_TIMEOUT_EN
        // watchdog with arready stuck low
        ar_delay = 100000; i_req_valid = 4'b0001;
        hit = 0;
        for (int c = 1; c <= 40; c++) begin
            tick();
            if (o_req_done != '0) begin hit = c; break; end
        end
        chk("to_cycle", 64'(hit), 64'd18);
        chk("to_err", {63'd0, o_rsp_err}, 64'd1);
        chk("to_data", {16'd0, o_rsp_data}, 64'd0);
        i_req_valid = '0;
        tick();
        chk("to_arvalid", {63'd0, o_arvalid}, 64'd0);
        ar_delay = 0;
`else
        hit = 0;
`endif

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
